video_mode_sequencer: RTL and testbench
=======================================

Name: video_mode_sequencer

Overview:
Controller that owns the timing configuration of the programmable video timing generator and sequences safe resolution changes. It accepts mode-change requests over a valid/ready handshake and waits for a frame boundary. It mutes the output, holds the generator in restart, loads the new timing set, releases the generator and unmutes after a settling period. It sits between the control/register block and the video generator/TMDS output path.

Parameters:
DEFAULT_MODE, 1, mode loaded out of reset (index into mode table)
MUTE_FRAMES, 2, frame_start pulses counted with output muted before the reload
UNMUTE_FRAMES, 1, frame_start pulses after restart before unmuting
RESTART_CYCLES, 16, clk cycles gen_enable is held low during the reload
TIMEOUT_CYCLES, 4194304, maximum wait for any single frame_start before proceeding anyway

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  mode-change request valid
req_mode  in  2  requested mode index
req_ready  out  1  high only in IDLE
frame_start  in  1  one-cycle pulse from generator at hpos=0, vpos=0
h_active/h_fporch/h_sync/h_bporch  out  12 each  horizontal timing to generator
v_active/v_fporch/v_sync/v_bporch  out  11 each  vertical timing to generator
cfg_load  out  1  one-cycle pulse: generator latches timing outputs
gen_enable  out  1  low = generator held at hpos=vpos=0, syncs inactive
video_mute  out  1  high = downstream forces RGB to 0 and de low
cur_mode  out  2  mode currently applied
busy  out  1  high in any state other than IDLE
err_invalid  out  1  one-cycle pulse on rejected request

Behaviour:
- Mode table, constant: 0 = 720p60 (1280,110,40,220 / 720,5,5,20). 1 = 1080p60 (1920,88,44,148 / 1080,4,5,36). 2 = 480p60 (640,16,96,48 / 480,10,2,33). 3 = reserved, invalid.
- Reset values: state BOOT, cur_mode=DEFAULT_MODE, timing outputs = table[DEFAULT_MODE], cfg_load=0, gen_enable=0, video_mute=1, req_ready=0, busy=1, err_invalid=0. All counters are 0.
- States and transitions:
  - BOOT: first cycle after rst release. Pulse cfg_load. Go to RESTART.
  - IDLE: req_ready=1. A handshake occurs on req_valid&&req_ready.
    - req_mode==3: err_invalid pulses the next cycle, stay IDLE.
    - req_mode==cur_mode: accepted as a no-op, stay IDLE.
    - Otherwise latch the target mode and go to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, set video_mute=1 and go to MUTE.
  - MUTE: count frame_start pulses. When the count reaches MUTE_FRAMES, go to LOAD.
  - LOAD: one cycle. gen_enable=0, timing outputs = table[target], cur_mode=target, cfg_load=1. Go to RESTART.
  - RESTART: gen_enable=0 for RESTART_CYCLES cycles (LOAD/BOOT cycle excluded), then gen_enable=1. Go to SETTLE.
  - SETTLE: count UNMUTE_FRAMES frame_start pulses, then video_mute=0 and go to IDLE.
- Timing outputs change only in LOAD (or reset) and are stable in all other states.
- frame_start while gen_enable=0 is ignored.
- Watchdog:
  - In WAIT_FRAME, MUTE and SETTLE, a counter resets on entry and on each frame_start.
  - When it reaches TIMEOUT_CYCLES, treat the event as a frame_start.
  - Width: ceil(log2(TIMEOUT_CYCLES+1)).
- req_valid in any non-IDLE state is not accepted (ready=0). The request must be held by the requester; no queueing.
- rst asserted mid-sequence: immediate return to reset values. The DEFAULT_MODE reload then runs via BOOT and the latched target is discarded.
- frame_start coincident with entry into a counting state counts toward that state only if that state is already current. Entry happens on the pulse itself; the pulse is not double-counted.
- Latency from accepted request to unmuted video: wait for the next frame plus MUTE_FRAMES frames, plus RESTART_CYCLES+1 cycles, plus UNMUTE_FRAMES frames.

Decomposition:
- Shared package video_timing_pkg:
  - mode index typedef and mode constants (MODE_720P=0, MODE_1080P=1, MODE_480P=2, MODE_RSVD=3)
  - packed timing-set struct (4×12-bit h, 4×11-bit v)
  - mode-table function
  - state enum
- One natural sub-module: video_frame_watchdog, the frame_start counter with timeout, reused by WAIT_FRAME/MUTE/SETTLE.

Test Plan:
- Reset release, DEFAULT_MODE=1, frame_start every 100 cycles (short test timings):
  - cfg_load pulses once at cycle 1 with h_active=1920, v_active=1080.
  - gen_enable rises 16 cycles later.
  - video_mute falls after 1 frame_start; req_ready=1.
- Request mode 0 in IDLE:
  - video_mute=1 at the next frame_start; 2 more frame_starts; cfg_load with h_active=1280, v_bporch=20, cur_mode=0.
  - gen_enable low 16 cycles; unmute after 1 frame_start.
- Request mode 3: err_invalid pulses 1 cycle; cur_mode, timing and mute are unchanged; req_ready stays 1.
- Request mode equal to cur_mode: accepted in 1 cycle, no cfg_load, no mute.
- Request mode 2 with frame_start stopped, TIMEOUT_CYCLES=64 in test:
  - sequence completes via watchdog at 64-cycle intervals.
  - final h_active=640, v_sync=2.
- rst pulse during RESTART of a 1080p→480p change: outputs return to 1080p table, BOOT reload runs, and the pending 480p change is discarded.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types for the video mode sequencer: mode indices, timing sets,
// the constant mode table and the sequencer state encoding.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_720P  = 2'd0,
    MODE_1080P = 2'd1,
    MODE_480P  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  localparam int H_W = 12;
  localparam int V_W = 11;

  typedef struct packed {
    logic [H_W-1:0] h_active;
    logic [H_W-1:0] h_fporch;
    logic [H_W-1:0] h_sync;
    logic [H_W-1:0] h_bporch;
    logic [V_W-1:0] v_active;
    logic [V_W-1:0] v_fporch;
    logic [V_W-1:0] v_sync;
    logic [V_W-1:0] v_bporch;
  } timing_set_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_MUTE,
    ST_LOAD,
    ST_RESTART,
    ST_SETTLE
  } seq_state_t;

  // The reserved index never reaches LOAD; it maps to all-zero timing.
  function automatic timing_set_t mode_timing(mode_t m);
    timing_set_t t;
    t = '0;
    case (m)
      MODE_720P: t = '{h_active: 12'd1280, h_fporch: 12'd110, h_sync: 12'd40, h_bporch: 12'd220,
                       v_active: 11'd720,  v_fporch: 11'd5,   v_sync: 11'd5,  v_bporch: 11'd20};
      MODE_1080P: t = '{h_active: 12'd1920, h_fporch: 12'd88, h_sync: 12'd44, h_bporch: 12'd148,
                        v_active: 11'd1080, v_fporch: 11'd4,  v_sync: 11'd5,  v_bporch: 11'd36};
      MODE_480P: t = '{h_active: 12'd640, h_fporch: 12'd16, h_sync: 12'd96, h_bporch: 12'd48,
                       v_active: 11'd480, v_fporch: 11'd10, v_sync: 11'd2,  v_bporch: 11'd33};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_if.sv
// Control-side request handshake plus the timing/enable/mute bundle that
// the sequencer presents to the video generator and output path.
interface video_mode_sequencer_if;
  import video_timing_pkg::*;

  logic           req_valid;
  mode_t          req_mode;
  logic           req_ready;
  logic           frame_start;
  logic [H_W-1:0] h_active;
  logic [H_W-1:0] h_fporch;
  logic [H_W-1:0] h_sync;
  logic [H_W-1:0] h_bporch;
  logic [V_W-1:0] v_active;
  logic [V_W-1:0] v_fporch;
  logic [V_W-1:0] v_sync;
  logic [V_W-1:0] v_bporch;
  logic           cfg_load;
  logic           gen_enable;
  logic           video_mute;
  mode_t          cur_mode;
  logic           busy;
  logic           err_invalid;

  modport master (
    output req_valid, req_mode, frame_start,
    input  req_ready, h_active, h_fporch, h_sync, h_bporch,
           v_active, v_fporch, v_sync, v_bporch,
           cfg_load, gen_enable, video_mute, cur_mode, busy, err_invalid
  );

  modport slave (
    input  req_valid, req_mode, frame_start,
    output req_ready, h_active, h_fporch, h_sync, h_bporch,
           v_active, v_fporch, v_sync, v_bporch,
           cfg_load, gen_enable, video_mute, cur_mode, busy, err_invalid
  );

endinterface

// File: rtl/video_frame_watchdog.sv
// Frame event source for the counting states: passes frame_start through and
// substitutes a synthetic event when no frame arrives within TIMEOUT_CYCLES.
module video_frame_watchdog
  import video_timing_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4194304
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic frame_start_i,
  output logic event_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          timeout;

  // Counter value k means k+1 cycles have elapsed since entry or the last event.
  assign timeout = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign event_o = active_i && (frame_start_i || timeout);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!active_i || event_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Owns the generator timing set and walks it through a mute / restart /
// reload / settle sequence whenever a different mode is requested.
module video_mode_sequencer
  import video_timing_pkg::*;
#(
  parameter mode_t DEFAULT_MODE   = MODE_1080P,
  parameter int    MUTE_FRAMES    = 2,
  parameter int    UNMUTE_FRAMES  = 1,
  parameter int    RESTART_CYCLES = 16,
  parameter int    TIMEOUT_CYCLES = 4194304
) (
  input  logic                  clk,
  input  logic                  rst,
  video_mode_sequencer_if.slave ctrl
);

  localparam int MAX_FRAMES = (MUTE_FRAMES > UNMUTE_FRAMES) ? MUTE_FRAMES : UNMUTE_FRAMES;
  localparam int FCW = $clog2(MAX_FRAMES + 1);
  localparam int RCW = $clog2(RESTART_CYCLES + 1);

  seq_state_t    state_q;
  mode_t         cur_mode_q;
  mode_t         target_q;
  timing_set_t   timing_q;
  logic          cfg_load_q;
  logic          gen_enable_q;
  logic          video_mute_q;
  logic          req_ready_q;
  logic          busy_q;
  logic          err_invalid_q;
  logic [FCW-1:0] frame_cnt_q;
  logic [RCW-1:0] restart_cnt_q;

  logic wd_active;
  logic frame_evt;

  assign wd_active = (state_q == ST_WAIT_FRAME) || (state_q == ST_MUTE) || (state_q == ST_SETTLE);

  // Pulses from a generator held in restart carry no frame information.
  video_frame_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .active_i     (wd_active),
    .frame_start_i(ctrl.frame_start && gen_enable_q),
    .event_o      (frame_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      cur_mode_q    <= DEFAULT_MODE;
      target_q      <= DEFAULT_MODE;
      timing_q      <= mode_timing(DEFAULT_MODE);
      cfg_load_q    <= 1'b0;
      gen_enable_q  <= 1'b0;
      video_mute_q  <= 1'b1;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      err_invalid_q <= 1'b0;
      frame_cnt_q   <= '0;
      restart_cnt_q <= '0;
    end else begin
      cfg_load_q    <= 1'b0;
      err_invalid_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          cfg_load_q    <= 1'b1;
          restart_cnt_q <= '0;
          state_q       <= ST_RESTART;
        end
        ST_IDLE: begin
          if (ctrl.req_valid && req_ready_q) begin
            if (ctrl.req_mode == MODE_RSVD) begin
              err_invalid_q <= 1'b1;
            end else if (ctrl.req_mode != cur_mode_q) begin
              target_q    <= ctrl.req_mode;
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= ST_WAIT_FRAME;
            end
          end
        end
        ST_WAIT_FRAME: begin
          // The entry pulse belongs to this state and is not counted in MUTE.
          if (frame_evt) begin
            video_mute_q <= 1'b1;
            frame_cnt_q  <= '0;
            state_q      <= ST_MUTE;
          end
        end
        ST_MUTE: begin
          if (frame_evt) begin
            if (frame_cnt_q == FCW'(MUTE_FRAMES - 1)) begin
              gen_enable_q <= 1'b0;
              state_q      <= ST_LOAD;
            end else begin
              frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
          end
        end
        ST_LOAD: begin
          timing_q      <= mode_timing(target_q);
          cur_mode_q    <= target_q;
          cfg_load_q    <= 1'b1;
          restart_cnt_q <= '0;
          state_q       <= ST_RESTART;
        end
        ST_RESTART: begin
          if (restart_cnt_q == RCW'(RESTART_CYCLES - 1)) begin
            gen_enable_q <= 1'b1;
            frame_cnt_q  <= '0;
            state_q      <= ST_SETTLE;
          end else begin
            restart_cnt_q <= restart_cnt_q + RCW'(1);
          end
        end
        ST_SETTLE: begin
          if (frame_evt) begin
            if (frame_cnt_q == FCW'(UNMUTE_FRAMES - 1)) begin
              video_mute_q <= 1'b0;
              req_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign ctrl.req_ready   = req_ready_q;
  assign ctrl.h_active    = timing_q.h_active;
  assign ctrl.h_fporch    = timing_q.h_fporch;
  assign ctrl.h_sync      = timing_q.h_sync;
  assign ctrl.h_bporch    = timing_q.h_bporch;
  assign ctrl.v_active    = timing_q.v_active;
  assign ctrl.v_fporch    = timing_q.v_fporch;
  assign ctrl.v_sync      = timing_q.v_sync;
  assign ctrl.v_bporch    = timing_q.v_bporch;
  assign ctrl.cfg_load    = cfg_load_q;
  assign ctrl.gen_enable  = gen_enable_q;
  assign ctrl.video_mute  = video_mute_q;
  assign ctrl.cur_mode    = cur_mode_q;
  assign ctrl.busy        = busy_q;
  assign ctrl.err_invalid = err_invalid_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for video_mode_sequencer: boot, a table of mode requests,
// a watchdog-driven change and a reset in the middle of a reload.
module tb_video_mode_sequencer;
  import video_timing_pkg::*;

  localparam int FRAME_PERIOD = 40;  // shorter than the 64-cycle watchdog used here

  localparam logic [91:0] T720  = {12'd1280, 12'd110, 12'd40, 12'd220, 11'd720,  11'd5,  11'd5, 11'd20};
  localparam logic [91:0] T1080 = {12'd1920, 12'd88,  12'd44, 12'd148, 11'd1080, 11'd4,  11'd5, 11'd36};
  localparam logic [91:0] T480  = {12'd640,  12'd16,  12'd96, 12'd48,  11'd480,  11'd10, 11'd2, 11'd33};

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  exp_cur;
    logic [91:0] exp_timing;
    int          exp_err;
    int          exp_loads;
    int          exp_mute_rise;
    int          exp_gen_low;
    int          exp_fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs_en = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  int   n_load = 0;
  int   n_err = 0;
  int   n_mute_rise = 0;
  int   n_gen_low = 0;
  int   n_fs_busy = 0;
  logic mute_prev = 1'b1;

  video_mode_sequencer_if bus ();

  video_mode_sequencer #(
    .DEFAULT_MODE  (MODE_1080P),
    .MUTE_FRAMES   (2),
    .UNMUTE_FRAMES (1),
    .RESTART_CYCLES(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus)
  );

  always #5 clk = ~clk;

  // Frame generator, driven just after the active edge.
  initial begin
    int fcnt;
    fcnt = 0;
    bus.frame_start = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (fs_en) begin
        fcnt++;
        bus.frame_start = ((fcnt % FRAME_PERIOD) == 0);
      end else begin
        fcnt = 0;
        bus.frame_start = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cfg_load) n_load++;
      if (bus.err_invalid) n_err++;
      if (bus.video_mute && !mute_prev) n_mute_rise++;
      if (!bus.gen_enable && bus.busy) n_gen_low++;
      if (bus.frame_start && bus.gen_enable && bus.busy) n_fs_busy++;
    end
    mute_prev = bus.video_mute;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got still running, expected $finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [91:0] cur_timing();
    return {bus.h_active, bus.h_fporch, bus.h_sync, bus.h_bporch,
            bus.v_active, bus.v_fporch, bus.v_sync, bus.v_bporch};
  endfunction

  task automatic do_req(input logic [1:0] m);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mode  = mode_t'(m);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int k;
    k = 0;
    while (!(bus.req_ready && !bus.busy) && k < max_cycles) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 128'(bus.req_ready && !bus.busy), 128'(1));
  endtask

  initial begin
    vec_t vecs[8];
    int   s_load, s_err, s_rise, s_low, s_fs;
    int   k, k_mute, k_load, k_unmute;

    vecs[0] = '{2'd0, 2'd0, T720,  0, 1, 1, 17, 4};
    vecs[1] = '{2'd3, 2'd0, T720,  1, 0, 0, 0,  0};
    vecs[2] = '{2'd0, 2'd0, T720,  0, 0, 0, 0,  0};
    vecs[3] = '{2'd1, 2'd1, T1080, 0, 1, 1, 17, 4};
    vecs[4] = '{2'd1, 2'd1, T1080, 0, 0, 0, 0,  0};
    vecs[5] = '{2'd2, 2'd2, T480,  0, 1, 1, 17, 4};
    vecs[6] = '{2'd3, 2'd2, T480,  1, 0, 0, 0,  0};
    vecs[7] = '{2'd0, 2'd0, T720,  0, 1, 1, 17, 4};

    bus.req_valid = 1'b0;
    bus.req_mode  = MODE_720P;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cur_mode", 128'(bus.cur_mode), 128'(1));
    check("rst_timing", 128'(cur_timing()), 128'(T1080));
    check("rst_cfg_load", 128'(bus.cfg_load), 128'(0));
    check("rst_gen_enable", 128'(bus.gen_enable), 128'(0));
    check("rst_video_mute", 128'(bus.video_mute), 128'(1));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(1));
    check("rst_err_invalid", 128'(bus.err_invalid), 128'(0));

    // Boot reload
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("boot_cfg_load", 128'(bus.cfg_load), 128'(1));
    check("boot_h_active", 128'(bus.h_active), 128'(1920));
    check("boot_v_active", 128'(bus.v_active), 128'(1080));
    k = 0;
    while (!bus.gen_enable && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) check("boot_cfg_load_single", 128'(bus.cfg_load), 128'(0));
    end
    check("boot_gen_enable_delay", 128'(k), 128'(16));
    s_fs = n_fs_busy;
    k = 0;
    while (bus.video_mute && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("boot_unmute", 128'(bus.video_mute), 128'(0));
    check("boot_unmute_frames", 128'(n_fs_busy - s_fs), 128'(1));
    check("boot_req_ready", 128'(bus.req_ready), 128'(1));
    check("boot_busy", 128'(bus.busy), 128'(0));
    $display("[TB] boot: cur_mode=%0d h_active=%0d gen_enable=%0d mute=%0d",
             bus.cur_mode, bus.h_active, bus.gen_enable, bus.video_mute);

    // Request table
    for (int i = 0; i < 8; i++) begin
      s_load = n_load;
      s_err  = n_err;
      s_rise = n_mute_rise;
      s_low  = n_gen_low;
      s_fs   = n_fs_busy;
      do_req(vecs[i].mode);
      repeat (3) @(posedge clk);
      #1;
      wait_idle(1000, $sformatf("vec%0d_idle", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cur_mode", i), 128'(bus.cur_mode), 128'(vecs[i].exp_cur));
      check($sformatf("vec%0d_timing", i), 128'(cur_timing()), 128'(vecs[i].exp_timing));
      check($sformatf("vec%0d_err_pulses", i), 128'(n_err - s_err), 128'(vecs[i].exp_err));
      check($sformatf("vec%0d_cfg_loads", i), 128'(n_load - s_load), 128'(vecs[i].exp_loads));
      check($sformatf("vec%0d_mute_rises", i), 128'(n_mute_rise - s_rise), 128'(vecs[i].exp_mute_rise));
      check($sformatf("vec%0d_gen_low_cycles", i), 128'(n_gen_low - s_low), 128'(vecs[i].exp_gen_low));
      check($sformatf("vec%0d_frames_busy", i), 128'(n_fs_busy - s_fs), 128'(vecs[i].exp_fs));
      check($sformatf("vec%0d_end_mute", i), 128'(bus.video_mute), 128'(0));
      check($sformatf("vec%0d_end_gen_enable", i), 128'(bus.gen_enable), 128'(1));
      $display("[TB] vec %0d: req_mode=%0d cur_mode=%0d h_active=%0d err=%0d loads=%0d gen_low=%0d",
               i, vecs[i].mode, bus.cur_mode, bus.h_active, n_err - s_err, n_load - s_load, n_gen_low - s_low);
    end

    // Watchdog-driven change 720p -> 480p with no frame_start
    fs_en = 1'b0;
    repeat (2) @(posedge clk);
    do_req(2'd2);
    k_mute = -1;
    k_load = -1;
    k_unmute = -1;
    for (int j = 1; j <= 400 && k_unmute < 0; j++) begin
      @(posedge clk);
      #1;
      if (k_mute < 0 && bus.video_mute) k_mute = j;
      if (k_load < 0 && bus.cfg_load) k_load = j;
      if (k_mute >= 0 && k_unmute < 0 && !bus.video_mute) k_unmute = j;
    end
    check("wd_mute_cycle", 128'(k_mute), 128'(64));
    check("wd_cfg_load_cycle", 128'(k_load), 128'(193));
    check("wd_unmute_cycle", 128'(k_unmute), 128'(273));
    check("wd_h_active", 128'(bus.h_active), 128'(640));
    check("wd_v_sync", 128'(bus.v_sync), 128'(2));
    check("wd_cur_mode", 128'(bus.cur_mode), 128'(2));
    $display("[TB] watchdog: mute@%0d load@%0d unmute@%0d h_active=%0d v_sync=%0d",
             k_mute, k_load, k_unmute, bus.h_active, bus.v_sync);
    fs_en = 1'b1;

    // Reset during RESTART of a 1080p -> 480p change
    do_req(2'd1);
    repeat (3) @(posedge clk);
    #1;
    wait_idle(1000, "rr_pre_idle");
    check("rr_pre_cur_mode", 128'(bus.cur_mode), 128'(1));
    do_req(2'd2);
    k = 0;
    while (!bus.cfg_load && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rr_reached_restart", 128'(bus.cfg_load), 128'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_rst_timing", 128'(cur_timing()), 128'(T1080));
    check("rr_rst_cur_mode", 128'(bus.cur_mode), 128'(1));
    check("rr_rst_gen_enable", 128'(bus.gen_enable), 128'(0));
    check("rr_rst_mute", 128'(bus.video_mute), 128'(1));
    check("rr_rst_busy", 128'(bus.busy), 128'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rr_boot_cfg_load", 128'(bus.cfg_load), 128'(1));
    s_load = n_load;
    wait_idle(1000, "rr_post_idle");
    repeat (200) @(posedge clk);
    #1;
    check("rr_final_cur_mode", 128'(bus.cur_mode), 128'(1));
    check("rr_final_timing", 128'(cur_timing()), 128'(T1080));
    check("rr_final_loads", 128'(n_load - s_load), 128'(1));
    check("rr_final_busy", 128'(bus.busy), 128'(0));
    check("rr_final_mute", 128'(bus.video_mute), 128'(0));
    $display("[TB] reset-in-restart: cur_mode=%0d h_active=%0d busy=%0d",
             bus.cur_mode, bus.h_active, bus.busy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
